// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the operand hazard scoreboard.
// The defaults describe a 3-deep forwarding pipe with load data ready in stage 2.
package scoreboard_pkg;

    localparam int DEF_NREG       = 8;
    localparam int DEF_NSRC       = 2;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOAD_STAGE = 2;
    localparam int DEF_SW         = $clog2(DEF_DEPTH + 1);

    typedef logic [DEF_SW-1:0] fwd_sel_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One register's pending-write tracker: remaining-stage count plus load flag.
// A count of DEPTH means the producer sits in EX; it ages toward zero each advance.
module scoreboard_entry
    import scoreboard_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          flush,
    input  logic          issue,
    input  logic          issue_load,
    output logic [SW-1:0] cnt,
    output logic          load
);

    logic [SW-1:0] cnt_q, cnt_d;
    logic          load_q, load_d;

    always_comb begin
        cnt_d  = cnt_q;
        load_d = load_q;
        if (advance) begin
            if (issue) begin
                cnt_d  = SW'(DEPTH);
                load_d = issue_load;
            end else if (cnt_q != '0) begin
                // A squashed EX producer never writes back
                if (flush && cnt_q == SW'(DEPTH)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
                if (cnt_d == '0) begin
                    load_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            load_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            load_q <= load_d;
        end
    end

    assign cnt  = cnt_q;
    assign load = load_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: picks forwarding stage per ID source operand
// and stalls ID when a source waits on a load not yet forwardable.
module hazard_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int  NREG       = DEF_NREG,
    parameter int  NSRC       = DEF_NSRC,
    parameter int  DEPTH      = DEF_DEPTH,
    parameter int  LOAD_STAGE = DEF_LOAD_STAGE,
    localparam int RW         = $clog2(NREG),
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     advance,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic                     issue_load,
    input  logic [RW-1:0]            issue_rd,
    input  logic [NSRC-1:0]          src_used,
    input  logic [NSRC-1:0][RW-1:0]  src_reg,
    output logic [NSRC-1:0][SW-1:0]  fwd_sel,
    output logic                     stall,
    output logic [NREG-1:0]          busy
);

    logic [SW-1:0] cnt [NREG];
    logic          ld  [NREG];

    logic [SW-1:0] src_cnt  [NSRC];
    logic          src_ld   [NSRC];
    logic [SW:0]   src_stg  [NSRC];
    logic [NSRC-1:0] src_dep;
    logic [NSRC-1:0] src_hold;

    logic issue_fire;

    assign issue_fire = issue_valid & issue_we & advance & ~stall & ~flush;

    for (genvar r = 0; r < NREG; r++) begin : g_entry
        scoreboard_entry #(
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .advance    (advance),
            .flush      (flush),
            .issue      (issue_fire && issue_rd == RW'(r)),
            .issue_load (issue_load),
            .cnt        (cnt[r]),
            .load       (ld[r])
        );
        assign busy[r] = (cnt[r] != '0);
    end

    // Lookups use pre-issue state, so a same-cycle rd==rs sees the older producer
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign src_cnt[i]  = cnt[src_reg[i]];
        assign src_ld[i]   = ld[src_reg[i]];
        assign src_stg[i]  = (SW+1)'(DEPTH + 1) - {1'b0, src_cnt[i]};
        assign src_dep[i]  = src_used[i] && (src_cnt[i] != '0);
        assign src_hold[i] = src_dep[i] && src_ld[i]
                             && (src_stg[i] < (SW+1)'(LOAD_STAGE));
        assign fwd_sel[i]  = src_dep[i] ? src_stg[i][SW-1:0] : '0;
    end

    assign stall = (|src_hold) && !reset;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: stage-position model plus directed pins.
// Model tracks each pending write by the stage its producer currently occupies.
module tb_hazard_scoreboard;

    localparam int NREG  = 8;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int LS    = 2;
    localparam int RW    = 3;
    localparam int SW    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    advance;
    logic                    flush;
    logic                    issue_valid;
    logic                    issue_we;
    logic                    issue_load;
    logic [RW-1:0]           issue_rd;
    logic [NSRC-1:0]         src_used;
    logic [NSRC-1:0][RW-1:0] src_reg;
    logic [NSRC-1:0][SW-1:0] fwd_sel;
    logic                    stall;
    logic [NREG-1:0]         busy;

    hazard_scoreboard #(
        .NREG       (NREG),
        .NSRC       (NSRC),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_load  (issue_load),
        .issue_rd    (issue_rd),
        .src_used    (src_used),
        .src_reg     (src_reg),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // stg[r]: stage of the youngest producer of r (0 = none), mld[r]: it is a load
    int stg [NREG];
    bit mld [NREG];
    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    function automatic bit m_stall();
        bit st;
        int r;
        st = 1'b0;
        if (reset) return 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            r = int'(src_reg[i]);
            if (src_used[i] && stg[r] != 0 && mld[r] && stg[r] < LS) st = 1'b1;
        end
        return st;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                stg[r] <= 0;
                mld[r] <= 1'b0;
            end
        end else if (advance) begin
            for (int r = 0; r < NREG; r++) begin
                if (stg[r] == 0) begin
                end else if ((flush && stg[r] == 1) || stg[r] == DEPTH) begin
                    stg[r] <= 0;
                    mld[r] <= 1'b0;
                end else begin
                    stg[r] <= stg[r] + 1;
                end
            end
            if (issue_valid && issue_we && !m_stall() && !flush) begin
                stg[issue_rd] <= 1;
                mld[issue_rd] <= issue_load;
            end
        end
    end

    task automatic compare();
        logic [NREG-1:0]         eb;
        logic [NSRC-1:0][SW-1:0] ef;
        logic                    es;
        int                      r;
        for (int k = 0; k < NREG; k++) eb[k] = (stg[k] != 0);
        for (int i = 0; i < NSRC; i++) begin
            r = int'(src_reg[i]);
            ef[i] = (src_used[i] && stg[r] != 0) ? SW'(stg[r]) : SW'(0);
        end
        es = m_stall();
        nvec++;
        if (busy !== eb || stall !== es || (!es && fwd_sel !== ef)) begin
            nerr++;
            $display("FAIL model t=%0t busy %b want %b stall %b want %b fwd %h want %h",
                     $time, busy, eb, stall, es, fwd_sel, ef);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (chk_on) compare();
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input bit v, input bit we, input bit ld, input int rd,
                       input bit [1:0] u, input int s0, input int s1,
                       input bit adv = 1'b1, input bit fl = 1'b0,
                       input bit rs = 1'b0);
        @(negedge clk);
        reset       = rs;
        advance     = adv;
        flush       = fl;
        issue_valid = v;
        issue_we    = we;
        issue_load  = ld;
        issue_rd    = RW'(rd);
        src_used    = u;
        src_reg[0]  = RW'(s0);
        src_reg[1]  = RW'(s1);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        reset       = 1'b1;
        advance     = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_load  = 1'b0;
        issue_rd    = '0;
        src_used    = '0;
        src_reg     = '0;

        drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1);
        chk_on = 1'b1;
        drv(0, 0, 0, 0, 2'b11, 1, 2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_stall", int'(stall), 0);
        chk("reset_fwd", int'(fwd_sel), 0);

        // ALU producer walks EX -> MEM -> WB -> retired
        drv(1, 1, 0, 3, 2'b00, 0, 0);
        drv(0, 0, 0, 0, 2'b01, 3, 0);
        chk("alu_fwd_s1", int'(fwd_sel[0]), 1);
        drv(0, 0, 0, 0, 2'b01, 3, 0);
        chk("alu_fwd_s2", int'(fwd_sel[0]), 2);
        drv(0, 0, 0, 0, 2'b01, 3, 0);
        chk("alu_fwd_s3", int'(fwd_sel[0]), 3);
        drv(0, 0, 0, 0, 2'b01, 3, 0);
        chk("alu_fwd_done", int'(fwd_sel[0]), 0);

        // Load-use: one bubble, then forward from stage 2
        drv(1, 1, 1, 5, 2'b00, 0, 0);
        drv(1, 1, 0, 7, 2'b10, 0, 5);
        chk("load_stall", int'(stall), 1);
        drv(1, 1, 0, 7, 2'b10, 0, 5);
        chk("load_unstall", int'(stall), 0);
        chk("load_fwd", int'(fwd_sel[1]), 2);
        idle(3);

        // WAW: newest producer wins, busy trails the second issue
        drv(1, 1, 0, 2, 2'b00, 0, 0);
        drv(1, 1, 0, 2, 2'b00, 0, 0);
        chk("waw_busy0", int'(busy[2]), 1);
        drv(0, 0, 0, 0, 2'b01, 2, 0);
        chk("waw_fwd", int'(fwd_sel[0]), 1);
        chk("waw_busy1", int'(busy[2]), 1);
        idle(1);
        chk("waw_busy2", int'(busy[2]), 1);
        idle(1);
        chk("waw_busy3", int'(busy[2]), 1);
        idle(1);
        chk("waw_busy4", int'(busy[2]), 0);

        // Flush kills the EX producer only
        drv(1, 1, 0, 6, 2'b00, 0, 0);
        drv(1, 1, 0, 4, 2'b00, 0, 0);
        drv(0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        drv(0, 0, 0, 0, 2'b11, 4, 6);
        chk("flush_busy4", int'(busy[4]), 0);
        chk("flush_fwd4", int'(fwd_sel[0]), 0);
        chk("flush_fwd6", int'(fwd_sel[1]), 3);
        idle(2);

        // Hold: state frozen and issue ignored
        drv(1, 1, 0, 1, 2'b00, 0, 0);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, 0, 1, 2'b01, 1, 0, 0);
            chk("hold_fwd", int'(fwd_sel[0]), 2);
        end
        drv(0, 0, 0, 0, 2'b01, 1, 0);
        chk("hold_after", int'(fwd_sel[0]), 2);
        idle(3);

        // Reset dominates pending state and a concurrent issue
        drv(1, 1, 0, 1, 2'b00, 0, 0);
        drv(1, 1, 0, 2, 2'b00, 0, 0);
        drv(1, 1, 1, 3, 2'b00, 0, 0);
        drv(1, 1, 0, 5, 2'b01, 3, 0, 1, 1, 1);
        chk("rst_pending", int'(busy), 14);
        chk("rst_stall_gated", int'(stall), 0);
        drv(0, 0, 0, 0, 2'b01, 3, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stall", int'(stall), 0);

        for (int n = 0; n < 3000; n++) begin
            drv(($urandom % 4) != 0, ($urandom % 5) != 0, ($urandom % 3) == 0,
                int'($urandom_range(0, NREG - 1)), 2'($urandom),
                int'($urandom_range(0, NREG - 1)),
                int'($urandom_range(0, NREG - 1)),
                ($urandom % 8) != 0, ($urandom % 10) == 0,
                ($urandom % 150) == 0);
        end

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
